vx_lsu_commit_arb: RTL
======================

// Module: vx_lsu_commit_arb
// PURPOSE
//  Downstream neighbour of the LSU. Merges the LSU load-commit and store-commit streams into one
//  registered commit port for the writeback/commit stage.
//  - Loads are buffered in a small FIFO so LSU response flow continues while commit is backpressured.
//  - Loads have priority; a starvation counter guarantees stores forward progress.
// PARAMETERS
//  NUM_THREADS   4  lanes per warp
//  NW_BITS       2  warp-id width
//  NR_BITS       5  destination register index width
//  LDQ_DEPTH     2  load FIFO entries (>=2, power of two)
//  STARVE_LIMIT  4  consecutive lost arbitrations before a store wins (0 = store always wins)
// PORTS
//  clk        in   1               clock
//  reset_n    in   1               synchronous reset, active-low
//  ld_valid   in   1               load commit valid
//  ld_ready   out  1               load commit accepted
//  ld_wid     in   NW_BITS         load warp id
//  ld_tmask   in   NUM_THREADS     load thread mask
//  ld_pc      in   32              load PC
//  ld_rd      in   NR_BITS         load destination register
//  ld_wb      in   1               load writeback enable
//  ld_data    in   NUM_THREADS*32  load data per lane
//  ld_eop     in   1               last packet of the load instruction
//  st_valid   in   1               store commit valid
//  st_ready   out  1               store commit accepted
//  st_wid     in   NW_BITS         store warp id
//  st_tmask   in   NUM_THREADS     store thread mask
//  st_pc      in   32              store PC
//  out_valid  out  1               commit valid
//  out_ready  in   1               commit consumer ready
//  out_wid, out_tmask, out_pc, out_rd, out_wb, out_data, out_eop  out  (as ld_*)  commit payload
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): FIFO empty, out_valid=0, out payload=0, starve_cnt=0,
//    perf counters=0. ld_ready=0 and st_ready=0 are forced combinationally while reset_n=0.
//  - Load FIFO
//    - push = ld_valid & ld_ready; ld_ready = ~fifo_full (no same-cycle push-on-pop when full).
//    - Pointers are log2(LDQ_DEPTH)+1 bits wide and wrap modulo 2*LDQ_DEPTH.
//  - Output register
//    - load_en = ~out_valid | out_ready.
//    - When load_en, the register takes the arbitration winner; out_valid=1 if a winner exists, else 0.
//    - Payload holds stable while out_valid & ~out_ready.
//  - Arbitration (combinational, evaluated only when load_en)
//    - Candidates: FIFO head (ld_pend = ~fifo_empty) and st_valid.
//    - st_prio = (starve_cnt >= STARVE_LIMIT).
//    - Winner: store if st_valid & (st_prio | ~ld_pend); otherwise load head if ld_pend.
//    - st_ready = load_en & store winner. Pop the FIFO when the load head wins.
//    - Store winner sets out_rd=0, out_wb=0, out_data=0, out_eop=1.
//  - starve_cnt
//    - Reset to 0 on a store grant or when ~st_valid.
//    - Otherwise incremented when st_valid & ~st_ready, saturating at STARVE_LIMIT.
//  - Latency: store 1 cycle (st fire at edge N -> out_valid at N+1). Load 2 cycles
//    (push at N, head visible N+1, out_valid at N+2).
//  - Ordering: loads leave in arrival order. eop is passed unchanged; packets are not merged or reordered.
//  - Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged.
//  - Empty FIFO with ~st_valid: out_valid falls to 0 on the next load_en.
//  - Reset mid-transfer discards FIFO contents and any pending output packet.
// CONFIGURATION
//  - LSU_COMMIT_PERF_EN defined: adds outputs perf_stall_cycles[31:0] (+1 each cycle with
//    out_valid & ~out_ready) and perf_starve_wins[31:0] (+1 on each store grant with st_prio=1).
//    Both wrap modulo 2^32 and clear on reset.
//  - LSU_COMMIT_PERF_EN undefined: these ports and counters do not exist. Functional behaviour is
//    identical in both cases.
// TESTING
//  1. Reset: hold reset_n=0 for 3 cycles with ld_valid=st_valid=1 -> out_valid=0, ld_ready=0,
//     st_ready=0; 1st cycle after release: ld_ready=1.
//  2. Single load: ld wid=1 pc=0x80000010 rd=5 data={4{0xDEADBEEF}} at N -> out_valid at N+2 with
//     identical payload and out_wb=1.
//  3. Store only: st wid=2 tmask=4'b1011 at N -> out_valid at N+1, out_rd=0, out_wb=0, out_eop=1.
//  4. Starvation: st_valid held with back-to-back loads, out_ready=1 -> 4 load grants, then the store
//     is granted; perf_starve_wins=1.
//  5. Backpressure: out_ready=0 for 6 cycles with 3 loads offered -> 2 accepted (LDQ_DEPTH=2),
//     ld_ready=0, payload stable, perf_stall_cycles=6. After release, loads drain in order.
//  6. Ordering: loads A(eop=0), B(eop=1), store S, out_ready=1 -> output order A, B, S with eop
//     values preserved.

Source files
------------

// File: rtl/vx_lsu_commit_arb.sv
// vx_lsu_commit_arb: merges the LSU load-commit and store-commit streams onto one registered commit port.
// Latency: store 1 cycle, load 2 cycles (through an LDQ_DEPTH-entry FIFO); loads leave in arrival order.
// Backpressure: out_ready_i low holds the output register; loads buffer until the FIFO is full, stores stall.
// Optional: define LSU_COMMIT_PERF_EN to add the perf_stall_cycles_o / perf_starve_wins_o counters.
module vx_lsu_commit_arb #(
   parameter int NUM_THREADS  = 4,
   parameter int NW_BITS      = 2,
   parameter int NR_BITS      = 5,
   parameter int LDQ_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       ld_valid_i,
   output logic                       ld_ready_o,
   input  logic [NW_BITS-1:0]         ld_wid_i,
   input  logic [NUM_THREADS-1:0]     ld_tmask_i,
   input  logic [31:0]                ld_pc_i,
   input  logic [NR_BITS-1:0]         ld_rd_i,
   input  logic                       ld_wb_i,
   input  logic [NUM_THREADS*32-1:0]  ld_data_i,
   input  logic                       ld_eop_i,
   input  logic                       st_valid_i,
   output logic                       st_ready_o,
   input  logic [NW_BITS-1:0]         st_wid_i,
   input  logic [NUM_THREADS-1:0]     st_tmask_i,
   input  logic [31:0]                st_pc_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [NW_BITS-1:0]         out_wid_o,
   output logic [NUM_THREADS-1:0]     out_tmask_o,
   output logic [31:0]                out_pc_o,
   output logic [NR_BITS-1:0]         out_rd_o,
   output logic                       out_wb_o,
   output logic [NUM_THREADS*32-1:0]  out_data_o,
   output logic                       out_eop_o
`ifdef LSU_COMMIT_PERF_EN
   ,
   output logic [31:0]                perf_stall_cycles_o,
   output logic [31:0]                perf_starve_wins_o
`endif
);

   localparam int AW   = $clog2(LDQ_DEPTH);
   localparam int PW   = AW + 1;
   localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

   typedef struct packed {
      logic [NW_BITS-1:0]        wid;
      logic [NUM_THREADS-1:0]    tmask;
      logic [31:0]               pc;
      logic [NR_BITS-1:0]        rd;
      logic                      wb;
      logic [NUM_THREADS*32-1:0] data;
      logic                      eop;
   } commit_t;

   commit_t          fifo_q [LDQ_DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic             out_valid_q;
   commit_t          out_q;

   logic             fifo_empty, fifo_full;
   logic             push, pop;
   logic             load_en, ld_pend, st_prio, st_pick, st_win, ld_win;
   commit_t          ld_pkt, st_pkt, head_pkt;

   // Full when the pointers address the same slot but are a lap apart (MSB differs).
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A full FIFO never accepts, even if the head leaves this cycle.
   assign ld_ready_o = reset_n_i & ~fifo_full;
   assign push       = ld_valid_i & ld_ready_o;

   // The output register only changes when empty or being consumed; arbitration is gated on that.
   assign load_en  = ~out_valid_q | out_ready_i;
   assign ld_pend  = ~fifo_empty;
   assign st_prio  = (starve_cnt_q >= SC_MAX);
   assign st_pick  = st_valid_i & (st_prio | ~ld_pend);
   assign st_win   = load_en & st_pick;
   assign ld_win   = load_en & ~st_pick & ld_pend;
   assign pop      = ld_win;

   assign st_ready_o = reset_n_i & st_win;

   assign ld_pkt   = '{wid: ld_wid_i, tmask: ld_tmask_i, pc: ld_pc_i, rd: ld_rd_i,
                       wb: ld_wb_i, data: ld_data_i, eop: ld_eop_i};
   // Stores carry no writeback: register, data and wb are zero and the packet is always a single eop.
   assign st_pkt   = '{wid: st_wid_i, tmask: st_tmask_i, pc: st_pc_i, rd: '0,
                       wb: 1'b0, data: '0, eop: 1'b1};
   assign head_pkt = fifo_q[rd_ptr_q[AW-1:0]];

   // Next-state for FIFO pointers and the store starvation counter.
   always_comb begin
      wr_ptr_d     = wr_ptr_q + PW'(push);
      rd_ptr_d     = rd_ptr_q + PW'(pop);
      starve_cnt_d = starve_cnt_q;
      if (st_win || !st_valid_i) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < SC_MAX) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // FIFO storage needs no reset: slots are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= ld_pkt;
      end
   end

   // Pointer and starvation state; reset discards any buffered loads.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         starve_cnt_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Output register takes the winner on load_en; payload is held otherwise.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (load_en) begin
         out_valid_q <= st_win | ld_win;
         if (st_win) begin
            out_q <= st_pkt;
         end else if (ld_win) begin
            out_q <= head_pkt;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_wid_o   = out_q.wid;
   assign out_tmask_o = out_q.tmask;
   assign out_pc_o    = out_q.pc;
   assign out_rd_o    = out_q.rd;
   assign out_wb_o    = out_q.wb;
   assign out_data_o  = out_q.data;
   assign out_eop_o   = out_q.eop;

`ifdef LSU_COMMIT_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_wins_q;

   // Stall cycles count held output; starve wins count store grants forced by the counter.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         perf_stall_q <= '0;
         perf_wins_q  <= '0;
      end else begin
         if (out_valid_q && !out_ready_i) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (st_win && st_prio) begin
            perf_wins_q <= perf_wins_q + 32'd1;
         end
      end
   end

   assign perf_stall_cycles_o = perf_stall_q;
   assign perf_starve_wins_o  = perf_wins_q;
`endif

endmodule
